dcache_snoop_responder: RTL and testbench
=========================================

# dcache_snoop_responder

Per-core coherence agent on the data-cache side of the cache-control bus. It is the snoop target for bus transactions started by the other core. It looks up the snooped block in the local 2-way dcache tag/state array, flushes a Modified block to memory, and downgrades the line to S or invalidates it to I. One instance sits beside each dcache, between the dcache arrays and the memory controller's coherence outputs for that core.

## Interface
Parameters:
- `TAG_W`, 26: tag width, address bits [31:6].
- `IDX_W`, 3: set index width, address bits [5:3]; 8 sets.

Address map: block offset is bit [2], word-aligned (bits [1:0] = 00). Each block holds 2 words.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `ccwait` in 1: this core is the snoop target; high for the whole remote transaction.
- `ccinv` in 1: remote transaction is BusRdX; invalidate on hit.
- `ccsnoopaddr` in 32: snooped byte address.
- `cctrans` out 1: high while supplying a flushed block.
- `ccwrite` out 1: tied 0; this block never initiates.
- `dWEN` out 1: memory write request.
- `daddr` out 32: memory write address.
- `dstore` out 32: memory write data.
- `dwait` in 1: low for one cycle when the current write is accepted.
- `snp_idx` out IDX_W: set index presented to the array.
- `snp_tag0`, `snp_tag1` in TAG_W each: tags of way 0 and way 1 at `snp_idx`.
- `snp_st0`, `snp_st1` in 2 each: line states; 00 = I, 01 = S, 10 = M, 11 treated as I.
- `snp_way` out 1: registered hit way. The array drives that way's data combinationally.
- `snp_word0`, `snp_word1` in 32 each: data words of way `snp_way`.
- `upd_en` out 1: one-cycle state-write strobe.
- `upd_way` out 1: way to update.
- `upd_st` out 2: new state for that way.
- `snoop_active` out 1: dcache must freeze array writes and its own miss FSM while high.

## Operation
States: IDLE, LOOKUP, FLUSH0, FLUSH1, UPDATE, RELEASE.

- **IDLE**
  - On `ccwait`=1: latch `ccsnoopaddr` (tag, idx) and `ccinv`, then go to LOOKUP.
- **LOOKUP**
  - Drive `snp_idx` from the latched index.
  - Hit: way w with state ≠ I and tag equal to the latched tag. Way 0 wins if both ways match.
  - If `ccwait`=0 this cycle: abort to IDLE with no update.
  - Miss: go to RELEASE.
  - Hit, state S, inv=0: go to RELEASE with no update.
  - Hit, state S, inv=1: latch w, go to UPDATE.
  - Hit, state M: latch w into `snp_way`, go to FLUSH0.
- **FLUSH0**
  - Drive `cctrans`=1, `dWEN`=1, `daddr`={tag, idx, 3'b000}, `dstore`=`snp_word0`.
  - Stay until `dwait`=0, then go to FLUSH1.
- **FLUSH1**
  - Same as FLUSH0 but `daddr`={tag, idx, 3'b100} and `dstore`=`snp_word1`.
  - On `dwait`=0, go to UPDATE.
  - Flush states ignore `ccwait`; a started flush always completes.
- **UPDATE**
  - `upd_en`=1, `upd_way`=latched way.
  - `upd_st`: I if inv=1, else S (covers both M→S and M→I).
  - Go to RELEASE.
- **RELEASE**
  - Wait for `ccwait`=0, then go to IDLE. This prevents re-snooping the same transaction.
- `snoop_active` = state ∈ {LOOKUP, FLUSH0, FLUSH1, UPDATE}.
- During IDLE with `ccwait`=1, the dcache already honours `ccwait` itself.

## Timing
- Reset: state IDLE. All outputs 0: `cctrans`, `dWEN`, `daddr`, `dstore`, `upd_*`, `snoop_active`, `snp_idx`, `snp_way`. Latches clear.
- All outputs decode combinationally from the registered state and latches. No output depends combinationally on `ccwait`.
- Latency from the first `ccwait`=1 edge:
  - LOOKUP is cycle 1.
  - S-invalidate: `upd_en` in cycle 2.
  - M flush: FLUSH0 starts in cycle 2; `upd_en` comes 1 cycle after FLUSH1 is accepted.
- A single `dwait`=0 cycle accepts exactly one word. `daddr`/`dstore` are stable while `dwait`=1.
- `RST` mid-flush: outputs drop immediately (asynchronous); the block is in IDLE on the next edge and the partial flush is discarded.

## Test plan
- **Miss:** `ccwait`↑, addr 0x00000040, both ways I → `snoop_active` high for 1 cycle; no `dWEN`/`upd_en`; RELEASE → IDLE after `ccwait`↓.
- **S invalidate:** addr 0x00000048, way1 tag 0x1 state S, `ccinv`=1 → `upd_en` in cycle 2 with `upd_way`=1, `upd_st`=00; no `dWEN`.
- **M downgrade:** addr 0x00001238, way0 tag 0x48 state M, words 0xDEADBEEF/0xCAFEF00D, `dwait` low after 2 cycles per word, `ccinv`=0 → writes 0x00001238←0xDEADBEEF then 0x0000123C←0xCAFEF00D with `cctrans`=1 throughout; then `upd_st`=01, way 0.
- **M invalidate with dual tag match:** as the previous case, but both ways match with state M and `ccinv`=1 → way 0 flushed; `upd_way`=0, `upd_st`=00.
- **Abort:** `ccwait` drops during LOOKUP on an S hit → IDLE; no `upd_en`; no re-snoop while `ccwait` stays 0.
- **Reset mid-flush:** `RST` asserted during FLUSH1 → `dWEN`, `cctrans`, `snoop_active` = 0 in the same cycle; IDLE after release; the next `ccwait` restarts normally.

Source files
------------

// File: rtl/dcache_snoop_responder.sv
// ---------------------------------------------------------------------------
// dcache_snoop_responder
//
// Snoop target for bus transactions started by the other core. It looks up
// the snooped block in the local 2-way dcache tag/state array. A Modified
// block is flushed to memory one word at a time. The line is then downgraded
// to S or invalidated to I.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   ccwait              remote transaction in progress (this core is target)
//   ccinv               remote transaction is BusRdX (invalidate on hit)
//   ccsnoopaddr         snooped byte address
//   cctrans             high while a flushed block is being supplied
//   ccwrite             never driven high; this block does not initiate
//   dWEN/daddr/dstore   memory write request, address, data
//   dwait               low for one cycle when the current word is accepted
//   snp_idx             set index presented to the tag/state/data array
//   snp_tag0/1,st0/1    tags and states of both ways at snp_idx
//   snp_way             latched hit way; the array returns that way's words
//   snp_word0/1         data words of way snp_way
//   upd_en/way/st       one-cycle state-write strobe to the array
//   snoop_active        dcache freezes array writes and its miss FSM
// ---------------------------------------------------------------------------
module dcache_snoop_responder #(
    parameter int TAG_W = 26,
    parameter int IDX_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ccwait,
    input  logic             ccinv,
    input  logic [31:0]      ccsnoopaddr,
    output logic             cctrans,
    output logic             ccwrite,
    output logic             dWEN,
    output logic [31:0]      daddr,
    output logic [31:0]      dstore,
    input  logic             dwait,
    output logic [IDX_W-1:0] snp_idx,
    input  logic [TAG_W-1:0] snp_tag0,
    input  logic [TAG_W-1:0] snp_tag1,
    input  logic [1:0]       snp_st0,
    input  logic [1:0]       snp_st1,
    output logic             snp_way,
    input  logic [31:0]      snp_word0,
    input  logic [31:0]      snp_word1,
    output logic             upd_en,
    output logic             upd_way,
    output logic [1:0]       upd_st,
    output logic             snoop_active
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_FLUSH0  = 3'd2;
    localparam logic [2:0] S_FLUSH1  = 3'd3;
    localparam logic [2:0] S_UPDATE  = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    logic [2:0]       r_state;
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;
    logic             r_inv;
    logic             r_way;

    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic             w_hit_way;
    logic [1:0]       w_hit_st;
    logic             w_flush;
    logic [2:0]       w_unused_off;

    // Block offset and byte bits never affect the lookup.
    assign w_unused_off = ccsnoopaddr[2:0];

    // State 11 is treated as invalid, so only S and M can hit.
    assign w_hit0    = ((snp_st0 == ST_S) || (snp_st0 == ST_M)) && (snp_tag0 == r_tag);
    assign w_hit1    = ((snp_st1 == ST_S) || (snp_st1 == ST_M)) && (snp_tag1 == r_tag);
    assign w_hit     = w_hit0 | w_hit1;
    // Way 0 has priority when both ways match.
    assign w_hit_way = ~w_hit0;
    assign w_hit_st  = w_hit0 ? snp_st0 : snp_st1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_tag   <= '0;
            r_idx   <= '0;
            r_inv   <= 1'b0;
            r_way   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ccwait) begin
                        r_tag   <= ccsnoopaddr[IDX_W+3 +: TAG_W];
                        r_idx   <= ccsnoopaddr[3 +: IDX_W];
                        r_inv   <= ccinv;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (!ccwait) begin
                        // Remote side gave up before we committed to anything.
                        r_state <= S_IDLE;
                    end else if (!w_hit) begin
                        r_state <= S_RELEASE;
                    end else if (w_hit_st == ST_M) begin
                        r_way   <= w_hit_way;
                        r_state <= S_FLUSH0;
                    end else if (r_inv) begin
                        r_way   <= w_hit_way;
                        r_state <= S_UPDATE;
                    end else begin
                        r_state <= S_RELEASE;
                    end
                end
                // Once started, a flush runs to completion regardless of ccwait.
                S_FLUSH0: if (!dwait) r_state <= S_FLUSH1;
                S_FLUSH1: if (!dwait) r_state <= S_UPDATE;
                S_UPDATE: r_state <= S_RELEASE;
                // Hold here until the remote transaction ends so the same
                // transaction is not snooped twice.
                S_RELEASE: if (!ccwait) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_flush      = (r_state == S_FLUSH0) || (r_state == S_FLUSH1);

    assign ccwrite      = 1'b0;
    assign cctrans      = w_flush;
    assign dWEN         = w_flush;
    assign daddr        = w_flush ? {r_tag, r_idx, (r_state == S_FLUSH1), 2'b00} : 32'd0;
    assign dstore       = (r_state == S_FLUSH0) ? snp_word0 :
                          (r_state == S_FLUSH1) ? snp_word1 : 32'd0;

    assign snp_idx      = r_idx;
    assign snp_way      = r_way;

    assign upd_en       = (r_state == S_UPDATE);
    assign upd_way      = upd_en & r_way;
    assign upd_st       = (upd_en && !r_inv) ? ST_S : ST_I;

    assign snoop_active = (r_state == S_LOOKUP) || w_flush || (r_state == S_UPDATE);

endmodule

// File: tb/tb_dcache_snoop_responder.sv
module tb_dcache_snoop_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        cctrans, ccwrite, dWEN;
    logic [31:0] daddr, dstore;
    logic        dwait;
    logic [2:0]  snp_idx;
    logic [25:0] snp_tag0, snp_tag1;
    logic [1:0]  snp_st0, snp_st1;
    logic        snp_way;
    logic [31:0] snp_word0, snp_word1;
    logic        upd_en, upd_way;
    logic [1:0]  upd_st;
    logic        snoop_active;

    // Behavioural dcache array: tags, states, two words per way.
    logic [25:0] m_tag [8][2];
    logic [1:0]  m_st  [8][2];
    logic [31:0] m_dat [8][2][2];

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dcache_snoop_responder #(.TAG_W(26), .IDX_W(3)) dut (
        .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .cctrans(cctrans), .ccwrite(ccwrite),
        .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait),
        .snp_idx(snp_idx), .snp_tag0(snp_tag0), .snp_tag1(snp_tag1),
        .snp_st0(snp_st0), .snp_st1(snp_st1), .snp_way(snp_way),
        .snp_word0(snp_word0), .snp_word1(snp_word1), .upd_en(upd_en),
        .upd_way(upd_way), .upd_st(upd_st), .snoop_active(snoop_active)
    );

    always_comb begin
        snp_tag0  = m_tag[snp_idx][0];
        snp_tag1  = m_tag[snp_idx][1];
        snp_st0   = m_st[snp_idx][0];
        snp_st1   = m_st[snp_idx][1];
        snp_word0 = m_dat[snp_idx][snp_way][0];
        snp_word1 = m_dat[snp_idx][snp_way][1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One remote transaction. Called 1ns after a rising edge.
    // d0/d1: stall cycles before each word is accepted.
    // abort: drop ccwait during the lookup cycle.
    // extra: cycles ccwait stays high after the snoop work is done.
    task automatic snoop(input logic [31:0] addr, input logic inv, input int d0, input int d1,
                         input bit abort, input int extra);
        int          idx;
        logic [25:0] tg;
        bit          hit0, hit1, hit;
        int          way;
        logic [1:0]  hst;
        int          exp_sa, exp_nw, exp_upc;
        logic [1:0]  exp_st;
        logic [31:0] ea [2];
        logic [31:0] ed [2];
        int          dd [2];
        int          tdrop, tend;
        int          sa_cnt, word, wcnt, bad_wd, bad_tr, ucnt, ucyc, uway, ust;
        logic        sa_c1;

        idx  = int'(addr[5:3]);
        tg   = addr[31:6];
        hit0 = (m_st[idx][0] == 2'b01 || m_st[idx][0] == 2'b10) && (m_tag[idx][0] == tg);
        hit1 = (m_st[idx][1] == 2'b01 || m_st[idx][1] == 2'b10) && (m_tag[idx][1] == tg);
        hit  = hit0 || hit1;
        way  = hit0 ? 0 : 1;
        hst  = m_st[idx][way];
        exp_nw = 0; exp_upc = 0; exp_sa = 1;
        exp_st = inv ? 2'b00 : 2'b01;
        if (!abort && hit) begin
            if (hst == 2'b10) begin
                exp_nw  = 2;
                exp_sa  = d0 + d1 + 4;   // lookup + two words + update
                exp_upc = exp_sa;
            end else if (inv) begin
                exp_sa  = 2;
                exp_upc = 2;
            end
        end
        ea[0] = {addr[31:3], 3'b000};
        ea[1] = {addr[31:3], 3'b100};
        ed[0] = m_dat[idx][way][0];
        ed[1] = m_dat[idx][way][1];
        dd[0] = d0; dd[1] = d1;
        tdrop = abort ? 1 : exp_sa + extra;
        tend  = tdrop + 3;

        sa_cnt = 0; word = 0; wcnt = 0; bad_wd = 0; bad_tr = 0;
        ucnt = 0; ucyc = 0; uway = 0; ust = 0; sa_c1 = 1'b0;

        ccsnoopaddr = addr;
        ccinv       = inv;
        ccwait      = 1'b1;
        dwait       = 1'b1;
        for (int c = 1; c <= tend; c++) begin
            @(posedge CLK); #1;
            if (c == tdrop) ccwait = 1'b0;
            if (c == 1) sa_c1 = snoop_active;
            if (snoop_active) sa_cnt++;
            if (cctrans !== dWEN) bad_tr++;
            if (dWEN) begin
                if (word >= 2) begin
                    bad_wd++;
                    dwait = 1'b0;
                end else begin
                    if (daddr !== ea[word] || dstore !== ed[word]) bad_wd++;
                    if (wcnt == dd[word]) begin
                        dwait = 1'b0;
                        word++;
                        wcnt = 0;
                    end else begin
                        dwait = 1'b1;
                        wcnt++;
                    end
                end
            end else begin
                dwait = 1'b1;
            end
            if (upd_en) begin
                ucnt++;
                ucyc = c;
                uway = int'(upd_way);
                ust  = int'(upd_st);
            end
        end
        dwait = 1'b1;

        chk("sa_cycle1", sa_c1, 1);
        chk("sa_cycles", sa_cnt, exp_sa);
        chk("wr_count", word, exp_nw);
        chk("wr_addr_data", bad_wd, 0);
        chk("cctrans_eq_dwen", bad_tr, 0);
        chk("upd_count", ucnt, (exp_upc > 0) ? 1 : 0);
        if (exp_upc > 0) begin
            chk("upd_cycle", ucyc, exp_upc);
            chk("upd_way", uway, way);
            chk("upd_st", ust, exp_st);
            m_st[idx][way] = exp_st;
        end
    endtask

    initial begin
        logic [31:0] a;
        bit          found;

        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w]    = '0;
                m_st[s][w]     = 2'b00;
                m_dat[s][w][0] = $urandom;
                m_dat[s][w][1] = $urandom;
            end
        RST = 1'b1; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0; dwait = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_dwen", dWEN, 0);
        chk("rst_cctrans", cctrans, 0);
        chk("rst_ccwrite", ccwrite, 0);
        chk("rst_daddr", daddr, 0);
        chk("rst_dstore", dstore, 0);
        chk("rst_upd", {upd_en, upd_way, upd_st}, 0);
        chk("rst_sa", snoop_active, 0);
        chk("rst_idx_way", {snp_idx, snp_way}, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Miss.
        snoop(32'h0000_0040, 1'b0, 0, 0, 1'b0, 1);
        // S invalidate on way 1.
        m_tag[1][1] = 26'h1; m_st[1][1] = 2'b01;
        snoop(32'h0000_0048, 1'b1, 0, 0, 1'b0, 0);
        // M downgrade with two stall cycles per word.
        m_tag[7][0] = 26'h48; m_st[7][0] = 2'b10;
        m_dat[7][0][0] = 32'hDEAD_BEEF; m_dat[7][0][1] = 32'hCAFE_F00D;
        snoop(32'h0000_1238, 1'b0, 2, 2, 1'b0, 1);
        // M invalidate with both ways matching: way 0 must win.
        m_st[7][0] = 2'b10;
        m_tag[7][1] = 26'h48; m_st[7][1] = 2'b10;
        m_dat[7][1][0] = 32'h1111_2222; m_dat[7][1][1] = 32'h3333_4444;
        snoop(32'h0000_1238, 1'b1, 1, 0, 1'b0, 2);
        // Abort during lookup on an S hit.
        m_tag[2][0] = 26'h5; m_st[2][0] = 2'b01;
        snoop({26'h5, 3'd2, 3'b000}, 1'b1, 0, 0, 1'b1, 0);

        // Reset during the second flush word.
        m_tag[4][0] = 26'h77; m_st[4][0] = 2'b10;
        a = {26'h77, 3'd4, 3'b000};
        ccsnoopaddr = a; ccinv = 1'b0; ccwait = 1'b1; dwait = 1'b1; found = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK); #1;
            if (dWEN && daddr[2]) begin
                found = 1;
                break;
            end
            dwait = dWEN ? 1'b0 : 1'b1;
        end
        chk("rst_flush1_reached", found, 1);
        dwait = 1'b1;
        #2;
        RST = 1'b1; ccwait = 1'b0;
        #1;
        chk("rstmid_dwen", dWEN, 0);
        chk("rstmid_cctrans", cctrans, 0);
        chk("rstmid_sa", snoop_active, 0);
        chk("rstmid_upd", upd_en, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rstmid_idle", snoop_active, 0);
        // Line was never updated, so a new snoop flushes it again.
        snoop(a, 1'b0, 1, 0, 1'b0, 0);

        // Randomised transactions against the array model.
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 2; k++) begin
                int s, w;
                s = int'($urandom_range(0, 7));
                w = int'($urandom_range(0, 1));
                m_tag[s][w]    = 26'($urandom_range(1, 3));
                m_st[s][w]     = 2'($urandom_range(0, 3));
                m_dat[s][w][0] = $urandom;
                m_dat[s][w][1] = $urandom;
            end
            a = {26'($urandom_range(1, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'b00};
            snoop(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
